// File: rtl/vga_timing_pkg.sv
// Shared raster-timing definitions: 800x600@60 defaults, derived-total
// helpers and a mode record for alternative resolutions.
package vga_timing_pkg;

    localparam int unsigned DEF_CLK_DIV  = 2;
    localparam int unsigned DEF_H_SYNC   = 128;
    localparam int unsigned DEF_H_BACK   = 88;
    localparam int unsigned DEF_H_ACTIVE = 800;
    localparam int unsigned DEF_H_FRONT  = 40;
    localparam int unsigned DEF_V_SYNC   = 4;
    localparam int unsigned DEF_V_BACK   = 23;
    localparam int unsigned DEF_V_ACTIVE = 600;
    localparam int unsigned DEF_V_FRONT  = 1;
    localparam bit          DEF_H_POL    = 1'b1;
    localparam bit          DEF_V_POL    = 1'b1;

    localparam int unsigned COUNT_W = 16;
    localparam int unsigned COORD_W = 11;

    // Full period of one axis: sync + back porch + active + front porch.
    function automatic int unsigned axis_total(input int unsigned sync_len,
                                               input int unsigned back_len,
                                               input int unsigned active_len,
                                               input int unsigned front_len);
        return sync_len + back_len + active_len + front_len;
    endfunction

    // First visible position on an axis; sync comes first, then back porch.
    function automatic int unsigned window_start(input int unsigned sync_len,
                                                 input int unsigned back_len);
        return sync_len + back_len;
    endfunction

    // Complete description of one video mode.
    typedef struct packed {
        logic [15:0] clk_div;
        logic [15:0] h_sync;
        logic [15:0] h_back;
        logic [15:0] h_active;
        logic [15:0] h_front;
        logic [15:0] v_sync;
        logic [15:0] v_back;
        logic [15:0] v_active;
        logic [15:0] v_front;
        logic        h_pol;
        logic        v_pol;
    } vga_mode_t;

    localparam vga_mode_t MODE_800X600_60 = '{
        clk_div:  16'(DEF_CLK_DIV),
        h_sync:   16'(DEF_H_SYNC),
        h_back:   16'(DEF_H_BACK),
        h_active: 16'(DEF_H_ACTIVE),
        h_front:  16'(DEF_H_FRONT),
        v_sync:   16'(DEF_V_SYNC),
        v_back:   16'(DEF_V_BACK),
        v_active: 16'(DEF_V_ACTIVE),
        v_front:  16'(DEF_V_FRONT),
        h_pol:    DEF_H_POL,
        v_pol:    DEF_V_POL
    };

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster-timing bundle from the timing generator to the pixel painter.
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    logic               pix_ce;
    logic [COUNT_W-1:0] hcount;
    logic [COUNT_W-1:0] vcount;
    logic               hsync;
    logic               vsync;
    logic               active;
    logic [COORD_W-1:0] pix_x;
    logic [COORD_W-1:0] pix_y;
    logic               line_start;
    logic               frame_start;

    modport master (
        output pix_ce, hcount, vcount, hsync, vsync, active,
               pix_x, pix_y, line_start, frame_start
    );

    modport slave (
        input  pix_ce, hcount, vcount, hsync, vsync, active,
               pix_x, pix_y, line_start, frame_start
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter with registered sync,
// window and in-window offset decode taken from the next-state count so
// every output moves on the same edge as the count itself.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned TOTAL = 1056,
    parameter int unsigned SYNC  = 128,
    parameter int unsigned START = 216,
    parameter int unsigned LEN   = 800,
    parameter bit          POL   = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step,
    output logic [COUNT_W-1:0] count,
    output logic               sync,
    output logic               in_window,
    output logic               wrap,
    output logic [COORD_W-1:0] offset
);

    localparam logic [COUNT_W-1:0] LAST    = COUNT_W'(TOTAL - 1);
    localparam logic [COUNT_W-1:0] SYNC_END = COUNT_W'(SYNC);
    localparam logic [COUNT_W-1:0] WIN_LO   = COUNT_W'(START);
    localparam logic [COUNT_W-1:0] WIN_HI   = COUNT_W'(START + LEN);

    logic [COUNT_W-1:0] count_d, count_q;
    logic               sync_d, sync_q;
    logic               in_window_d, in_window_q;
    logic [COORD_W-1:0] offset_d, offset_q;
    logic [COUNT_W-1:0] rel;

    // Next position and its decode; wrap is the combinational "this step rolls over".
    always_comb begin
        wrap        = step && (count_q == LAST);
        count_d     = count_q;
        if (step) begin
            count_d = wrap ? '0 : count_q + COUNT_W'(1);
        end
        sync_d      = (count_d < SYNC_END) ? POL : ~POL;
        in_window_d = (count_d >= WIN_LO) && (count_d < WIN_HI);
        rel         = count_d - WIN_LO;
        offset_d    = in_window_d ? rel[COORD_W-1:0] : '0;
    end

    // Position and decode registers; reset parks the axis at the start of sync.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            sync_q      <= POL;
            in_window_q <= 1'b0;
            offset_q    <= '0;
        end else begin
            count_q     <= count_d;
            sync_q      <= sync_d;
            in_window_q <= in_window_d;
            offset_q    <= offset_d;
        end
    end

    assign count     = count_q;
    assign sync      = sync_q;
    assign in_window = in_window_q;
    assign offset    = offset_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source for the pixel painter: pixel-rate enable, H/V
// counters, sync pulses, active flag, active-area coordinates and
// line/frame start strobes, all aligned to the same clock edge.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BACK   = DEF_H_BACK,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FRONT  = DEF_H_FRONT,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BACK   = DEF_V_BACK,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FRONT  = DEF_V_FRONT,
    parameter bit          H_POL    = DEF_H_POL,
    parameter bit          V_POL    = DEF_V_POL
) (
    input  logic             clk,
    input  logic             rst,
    vga_timing_gen_if.master vif
);

    localparam int unsigned H_TOTAL  = axis_total(H_SYNC, H_BACK, H_ACTIVE, H_FRONT);
    localparam int unsigned V_TOTAL  = axis_total(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);
    localparam int unsigned HA_START = window_start(H_SYNC, H_BACK);
    localparam int unsigned VA_START = window_start(V_SYNC, V_BACK);
    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    // Configurations the counters cannot represent are rejected at elaboration.
    if (CLK_DIV < 1 || H_TOTAL > 65535 || V_TOTAL > 65535) begin : g_bad_cfg
        $fatal(1, "vga_timing_gen: CLK_DIV must be >= 1 and axis totals must fit in 16 bits");
    end

    logic [DIV_W-1:0]   div_cnt_d, div_cnt_q;
    logic               pix_ce_d, pix_ce_q;
    logic               line_start_d, line_start_q;
    logic               frame_start_d, frame_start_q;

    logic [COUNT_W-1:0] h_count, v_count;
    logic               h_sync, v_sync;
    logic               h_in, v_in;
    logic               h_wrap, v_wrap;
    logic               v_step;
    logic [COORD_W-1:0] h_off, v_off;
    logic               active;

    // Pixel divider; the counters step on the same edge that raises pix_ce.
    always_comb begin
        div_cnt_d     = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
        pix_ce_d      = (div_cnt_d == DIV_LAST);
        v_step        = pix_ce_d && h_wrap;
        line_start_d  = h_wrap;
        frame_start_d = h_wrap && v_wrap;
    end

    // Divider and strobe registers; strobes are idle out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q     <= '0;
            pix_ce_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            pix_ce_q      <= pix_ce_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    vga_axis_counter #(
        .TOTAL (H_TOTAL),
        .SYNC  (H_SYNC),
        .START (HA_START),
        .LEN   (H_ACTIVE),
        .POL   (H_POL)
    ) u_h_axis (
        .clk       (clk),
        .rst       (rst),
        .step      (pix_ce_d),
        .count     (h_count),
        .sync      (h_sync),
        .in_window (h_in),
        .wrap      (h_wrap),
        .offset    (h_off)
    );

    vga_axis_counter #(
        .TOTAL (V_TOTAL),
        .SYNC  (V_SYNC),
        .START (VA_START),
        .LEN   (V_ACTIVE),
        .POL   (V_POL)
    ) u_v_axis (
        .clk       (clk),
        .rst       (rst),
        .step      (v_step),
        .count     (v_count),
        .sync      (v_sync),
        .in_window (v_in),
        .wrap      (v_wrap),
        .offset    (v_off)
    );

    // Both window flags are registered, so gating them here adds no skew.
    assign active          = h_in && v_in;
    assign vif.pix_ce      = pix_ce_q;
    assign vif.hcount      = h_count;
    assign vif.vcount      = v_count;
    assign vif.hsync       = h_sync;
    assign vif.vsync       = v_sync;
    assign vif.active      = active;
    assign vif.pix_x       = active ? h_off : '0;
    assign vif.pix_y       = active ? v_off : '0;
    assign vif.line_start  = line_start_q;
    assign vif.frame_start = frame_start_q;

endmodule
